// File: rtl/mdu_sequencer_pkg.sv
// Shared types for the E-stage multiply/divide sequencer: op codes, HI/LO pair, FSM states.
// Purely declarative; no latency or flow control of its own.
package mdu_sequencer_pkg;

    localparam int MDU_OP_W = 3;

    // Codes 6 and 7 are reserved and deliberately left out of the enum.
    typedef enum logic [MDU_OP_W-1:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } md_op_t;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit multiply / divide result select by op code.
// Latency: zero (pure combinational).
// Backpressure: none; the sequencer decides when the result is captured.
module mdu_arith
    import mdu_sequencer_pkg::*;
(
    input  md_op_t      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output hilo_t       res
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] div_b;
    logic               div_ovf;
    logic signed [31:0] q_s;
    logic signed [31:0] r_s;
    logic        [31:0] q_u;
    logic        [31:0] r_u;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    // A zero divisor never reaches HI/LO, so substitute 1 to keep the dividers free of X.
    assign div_b   = (b == 32'd0) ? 32'd1 : b;
    // Most-negative / -1 overflows the signed quotient; pin it to a defined value.
    assign div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    assign q_s = div_ovf ? $signed(a)    : $signed(a) / $signed(div_b);
    assign r_s = div_ovf ? 32'sd0        : $signed(a) % $signed(div_b);
    assign q_u = a / div_b;
    assign r_u = a % div_b;

    always_comb begin
        res = '0;
        case (op)
            MDU_MULT:  res = prod_s;
            MDU_MULTU: res = prod_u;
            MDU_DIV:   begin res.hi = r_s; res.lo = q_s; end
            MDU_DIVU:  begin res.hi = r_u; res.lo = q_u; end
            default:   res = '0;
        endcase
    end

endmodule

// File: rtl/mdu_sequencer.sv
// E-stage multiply/divide sequencer with architectural HI/LO and D-stage stall request.
// Latency: MULT/DIV hold busy for MUL_CYCLES/DIV_CYCLES, HI/LO visible the cycle after; MTHI/MTLO one edge.
// Backpressure: stall_req holds an MD instruction in D while an op is starting or in flight.
module mdu_sequencer
    import mdu_sequencer_pkg::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                E_start,
    input  logic [MDU_OP_W-1:0] E_md_op,
    input  logic [31:0]         E_src_a,
    input  logic [31:0]         E_src_b,
    input  logic                D_is_md,
    output logic                busy,
    output logic                stall_req,
    output logic [31:0]         hi,
    output logic [31:0]         lo
);

    localparam int CNT_W = $clog2(max_int(MUL_CYCLES, DIV_CYCLES) + 1);

    mdu_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    hilo_t            staged_q, staged_d;
    logic             skip_q, skip_d;
    hilo_t            hilo_q, hilo_d;
    hilo_t            arith_res;
    md_op_t           op;

    assign op = md_op_t'(E_md_op);

    mdu_arith u_arith (
        .op  (op),
        .a   (E_src_a),
        .b   (E_src_b),
        .res (arith_res)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        staged_d = staged_q;
        skip_d   = skip_q;
        hilo_d   = hilo_q;
        unique case (state_q)
            ST_IDLE: begin
                if (E_start) begin
                    case (op)
                        MDU_MULT, MDU_MULTU: begin
                            staged_d = arith_res;
                            skip_d   = 1'b0;
                            cnt_d    = CNT_W'(MUL_CYCLES);
                            state_d  = ST_BUSY;
                        end
                        MDU_DIV, MDU_DIVU: begin
                            // Divide by zero still occupies the unit but leaves HI/LO alone.
                            staged_d = arith_res;
                            skip_d   = (E_src_b == 32'd0);
                            cnt_d    = CNT_W'(DIV_CYCLES);
                            state_d  = ST_BUSY;
                        end
                        MDU_MTHI: hilo_d.hi = E_src_a;
                        MDU_MTLO: hilo_d.lo = E_src_a;
                        default: ;
                    endcase
                end
            end
            ST_BUSY: begin
                // Starts arriving while busy are dropped; hazard control keeps them out.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    if (!skip_q) begin
                        hilo_d = staged_q;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            staged_q <= '0;
            skip_q   <= 1'b0;
            hilo_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            staged_q <= staged_d;
            skip_q   <= skip_d;
            hilo_q   <= hilo_d;
        end
    end

    assign busy      = (state_q == ST_BUSY);
    assign stall_req = D_is_md & (busy | E_start);
    assign hi        = hilo_q.hi;
    assign lo        = hilo_q.lo;

endmodule
